// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider.
// Produces one quotient bit per clock and presents the quotient and remainder
// with a one-cycle write strobe (wenable/wdata feed the result register).
// Optional feature: define DIV_SIGNED_EN to add the signed_op port, which
// selects two's-complement truncating division. Otherwise all operations are
// unsigned.
// state_dbg exposes the FSM state for observation only.
//
// Handshake: start is a request that is sampled only while busy=0. A start
// seen while busy=1 is dropped, not queued. busy rises on the accept edge and
// falls on the edge that ends the single wenable cycle. wdata, rem_out and dbz
// are valid while wenable=1 and hold their values until the next result.
module div_unit #(
   parameter int data_size = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [data_size-1:0] dividend,
   input  logic [data_size-1:0] divisor,
`ifdef DIV_SIGNED_EN
   input  logic                 signed_op,
`endif
   output logic                 busy,
   output logic                 wenable,
   output logic [data_size-1:0] wdata,
   output logic [data_size-1:0] rem_out,
   output logic                 dbz,
   output logic [1:0]           state_dbg
);

   localparam int CW = $clog2(data_size + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(data_size);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [data_size-1:0] rem;     // partial remainder
   logic [data_size-1:0] quo;     // dividend shifting out / quotient shifting in
   logic [data_size-1:0] dvs;     // captured divisor magnitude
   logic                 neg_q;   // negate quotient at the end
   logic                 neg_r;   // negate remainder at the end

   logic                 op_signed;
   logic [data_size-1:0] dvd_mag;
   logic [data_size-1:0] dvs_mag;

   logic [data_size:0]   shifted;
   logic [data_size:0]   diff;
   logic [data_size-1:0] rem_nxt;
   logic [data_size-1:0] quo_nxt;
   logic [data_size-1:0] q_fin;
   logic [data_size-1:0] r_fin;

`ifdef DIV_SIGNED_EN
   assign op_signed = signed_op;
`else
   assign op_signed = 1'b0;
`endif

   assign state_dbg = state;

   // Operand magnitudes at accept time (identity for unsigned operations)
   always_comb begin
      dvd_mag = dividend;
      dvs_mag = divisor;
      if (op_signed && dividend[data_size-1]) dvd_mag = -dividend;
      if (op_signed && divisor[data_size-1])  dvs_mag = -divisor;
   end

   // One restoring step.
   // The partial remainder is always below dvs, so shifted - dvs lies in
   // [-dvs, dvs-1]. That range fits a (data_size+1)-bit signed value, so the
   // top bit of diff is the sign of the trial subtraction.
   always_comb begin
      shifted = {rem, quo[data_size-1]};
      diff    = shifted - {1'b0, dvs};
      if (diff[data_size]) begin
         rem_nxt = shifted[data_size-1:0];
         quo_nxt = {quo[data_size-2:0], 1'b0};
      end else begin
         rem_nxt = diff[data_size-1:0];
         quo_nxt = {quo[data_size-2:0], 1'b1};
      end
      q_fin = neg_q ? -quo_nxt : quo_nxt;
      r_fin = neg_r ? -rem_nxt : rem_nxt;
   end

   // Control FSM with registered busy/wenable and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         wenable <= 1'b0;
         dbz     <= 1'b0;
         wdata   <= '0;
         rem_out <= '0;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     dvs   <= dvs_mag;
                     quo   <= dvd_mag;
                     rem   <= '0;
                     cnt   <= CNT_INIT;
                     neg_q <= op_signed & (dividend[data_size-1] ^ divisor[data_size-1]);
                     neg_r <= op_signed & dividend[data_size-1];
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     wdata   <= '1;
                     rem_out <= dividend;
                     dbz     <= 1'b1;
                     state   <= DONE;
                     busy    <= 1'b1;
                     wenable <= 1'b1;
                  end
               end
            end
            RUN: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  wdata   <= q_fin;
                  rem_out <= r_fin;
                  dbz     <= 1'b0;
                  state   <= DONE;
                  wenable <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               busy    <= 1'b0;
               wenable <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               wenable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks for div_unit (data_size = 16).
// A cycle-level reference model derived from plain division arithmetic is
// compared with every DUT output on each falling edge. A queue of
// hand-computed results is consumed on every wenable pulse.
module tb_div_unit;

   localparam int W = 16;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         sg_in;
   logic         busy;
   logic         wenable;
   logic [W-1:0] wdata;
   logic [W-1:0] rem_out;
   logic         dbz;
   logic [1:0]   state_dbg;

   always #5 clk = ~clk;

   div_unit #(.data_size(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef DIV_SIGNED_EN
      .signed_op (sg_in),
`endif
      .busy      (busy),
      .wenable   (wenable),
      .wdata     (wdata),
      .rem_out   (rem_out),
      .dbz       (dbz),
      .state_dbg (state_dbg)
   );

   // ---------------- check bookkeeping ----------------
   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // m_timer counts the cycles busy still has to stay high.
   // The result becomes visible when the timer reaches 1, which is the
   // wenable cycle.
   int           m_timer = 0;
   logic         m_busy  = 1'b0;
   logic         m_wen   = 1'b0;
   logic [W-1:0] m_wdata = '0;
   logic [W-1:0] m_rem   = '0;
   logic         m_dbz   = 1'b0;
   logic [W-1:0] p_q;
   logic [W-1:0] p_r;

   always @(posedge clk) begin
      int  qi;
      int  ri;
      logic m_sg;
`ifdef DIV_SIGNED_EN
      m_sg = sg_in;
`else
      m_sg = 1'b0;
`endif
      if (rst) begin
         m_timer = 0;
         m_wdata = '0;
         m_rem   = '0;
         m_dbz   = 1'b0;
      end else if (m_timer > 0) begin
         m_timer--;
         if (m_timer == 1) begin
            m_wdata = p_q;
            m_rem   = p_r;
            m_dbz   = 1'b0;
         end
      end else if (start === 1'b1) begin
         if (divisor == '0) begin
            m_timer = 1;
            m_wdata = '1;
            m_rem   = dividend;
            m_dbz   = 1'b1;
         end else begin
            m_timer = W + 1;
            if (m_sg) begin
               qi = int'($signed(dividend)) / int'($signed(divisor));
               ri = int'($signed(dividend)) % int'($signed(divisor));
            end else begin
               qi = int'(dividend) / int'(divisor);
               ri = int'(dividend) % int'(divisor);
            end
            p_q = qi[W-1:0];
            p_r = ri[W-1:0];
         end
      end
      m_busy = (m_timer > 0);
      m_wen  = (m_timer == 1);
   end

   // ---------------- scoreboard ----------------
   logic [2*W:0] exp_q[$];   // {dbz, quotient, remainder}

   // Compare process: every output against the model, pulses against exp_q
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",    busy,    m_busy);
         check("wenable", wenable, m_wen);
         check("wdata",   wdata,   m_wdata);
         check("rem_out", rem_out, m_rem);
         check("dbz",     dbz,     m_dbz);
         if (wenable === 1'b1) begin
            if (exp_q.size() == 0) check("extra_pulse", 1, 0);
            else check("sb_result", {dbz, wdata, rem_out}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge with the DUT idle. Returns just after
   // the edge that closes the wenable cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                         input int exp_lat);
      int  lat;
      bit  seen;
      exp_q.push_back({edbz, eq, er});
      dividend = a;
      divisor  = b;
      sg_in    = sg;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat  = -1;
      seen = 1'b0;
      do begin
         lat++;
         @(negedge clk);
         if (wenable === 1'b1) seen = 1'b1;
      end while (!seen && lat < 100);
      check("latency", lat, exp_lat);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int first_lat;
      int seen;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; sg_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("reset_busy",  busy,  0);
      check("reset_wdata", wdata, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 100/7: quotient 14 remainder 2, wenable 16 edges after accept
      run_op(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 16);
      // divide by zero: immediate result
      run_op(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 0);
      // small directed vectors
      run_op(16'd0,     16'd5,     1'b0, 16'd0,     16'd0, 1'b0, 16);
      run_op(16'd3,     16'd10,    1'b0, 16'd0,     16'd3, 1'b0, 16);
      run_op(16'hFFFF,  16'hFFFF,  1'b0, 16'd1,     16'd0, 1'b0, 16);
      run_op(16'hFFFF,  16'd2,     1'b0, 16'd32767, 16'd1, 1'b0, 16);
      run_op(16'd1000,  16'd10,    1'b0, 16'd100,   16'd0, 1'b0, 16);
      run_op(16'h8000,  16'd3,     1'b0, 16'd10922, 16'd2, 1'b0, 16);

      // 0xFFFF/1 with starts at E5 and E16 that must be ignored
      exp_q.push_back({1'b0, 16'hFFFF, 16'h0000});
      dividend = 16'hFFFF; divisor = 16'd1; start = 1'b1;
      @(posedge clk); #1;                      // E0
      start = 1'b0;
      repeat (4) @(posedge clk); #1;           // E4
      start = 1'b1; dividend = 16'd7; divisor = 16'd3;
      @(posedge clk); #1;                      // E5
      start = 1'b0;
      repeat (10) @(posedge clk); #1;          // E15
      start = 1'b1; dividend = 16'd9; divisor = 16'd0;
      @(posedge clk); #1;                      // E16
      start = 1'b0;
      repeat (4) @(posedge clk); #1;

      // reset at E8 of 500/3 discards the result
      dividend = 16'd500; divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1;                      // E0
      start = 1'b0;
      repeat (7) @(posedge clk); #1;           // E7
      rst = 1'b1;
      @(posedge clk); #1;                      // E8
      rst = 1'b0;
      check("rst_busy",    busy,    0);
      check("rst_wenable", wenable, 0);
      check("rst_wdata",   wdata,   0);
      check("rst_rem",     rem_out, 0);
      run_op(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0, 16);

      // back-to-back with start held high: 9/3 then 10/4
      exp_q.push_back({1'b0, 16'd3, 16'd0});
      exp_q.push_back({1'b0, 16'd2, 16'd2});
      dividend = 16'd9; divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1;                      // E0
      dividend = 16'd10; divisor = 16'd4;
      lat = -1; seen = 0; first_lat = -1;
      do begin
         lat++;
         @(negedge clk);
         if (wenable === 1'b1) begin
            seen++;
            if (seen == 1) first_lat = lat;
         end
      end while (seen < 2 && lat < 200);
      start = 1'b0;
      check("b2b_first_lat",  first_lat, 16);
      check("b2b_second_lat", lat,       34);
      @(posedge clk); #1;

`ifdef DIV_SIGNED_EN
      run_op(16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 16);
      run_op(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 16);
      run_op(16'hFFF9, 16'd2,    1'b0, 16'h7FFC, 16'h0001, 1'b0, 16);
      run_op(16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 16);
      run_op(16'hFFF9, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
